// File: rtl/rng_ci_master.sv
// rng_ci_master
//   Initiator for the die-roll RNG custom-instruction handshake. A roll request
//   (die code, roll count) becomes a burst of start/dataa/datab transactions.
//   Each transaction waits on done, captures result[4:0] and adds it to a
//   running burst sum.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   i_roll            request pulse, accepted only while idle
//   i_dieSelect[3:0]  die code, latched on an accepted request
//   i_numRolls[2:0]   rolls per burst minus one, latched on an accepted request
//   ci_clk_en         high while a transaction is issued or awaited
//   ci_start          one-cycle strobe per transaction
//   ci_dataa[31:0]    zero-extended latched die code
//   ci_datab[31:0]    constant zero
//   ci_result[31:0]   responder result (bits [4:0] used)
//   ci_done           responder done (level or pulse)
//   o_busy            high whenever not idle
//   o_lastRoll[4:0]   most recent captured roll
//   o_sum[7:0]        burst sum
//   o_valid           one-cycle pulse on successful burst completion
//   o_timeout         one-cycle pulse when a transaction times out
module rng_ci_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_roll,
  input  logic [3:0]  i_dieSelect,
  input  logic [2:0]  i_numRolls,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [31:0] ci_dataa,
  output logic [31:0] ci_datab,
  input  logic [31:0] ci_result,
  input  logic        ci_done,
  output logic        o_busy,
  output logic [4:0]  o_lastRoll,
  output logic [7:0]  o_sum,
  output logic        o_valid,
  output logic        o_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ISSUE,
    WAIT,
    GAP,
    DONE,
    ABORT
  } state_t;

  state_t        state_q;
  logic [3:0]    die_q;
  logic [2:0]    num_q;
  logic [2:0]    roll_cnt_q;
  logic [TW-1:0] wait_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          clk_en_q;
  logic          start_q;
  logic          busy_q;
  logic [4:0]    last_q;
  logic [7:0]    sum_q;
  logic          valid_q;
  logic          timeout_q;
  logic [7:0]    sum_d;

  // Only the low five result bits carry the roll.
  logic unused_result;
  assign unused_result = ^ci_result[31:5];

  always_comb begin
    sum_d = sum_q + {3'b000, ci_result[4:0]};
  end

  // Outputs are registered: each is set on the transition into the state
  // that owns it, so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      die_q      <= '0;
      num_q      <= '0;
      roll_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      clk_en_q   <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_roll) begin
            die_q      <= i_dieSelect;
            num_q      <= i_numRolls;
            sum_q      <= '0;
            roll_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          // A done level left over from the previous roll must clear first.
          if (!ci_done) begin
            start_q  <= 1'b1;
            clk_en_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // Done takes priority over an expiring timeout on the same cycle.
          if (ci_done) begin
            last_q     <= ci_result[4:0];
            sum_q      <= sum_d;
            roll_cnt_q <= roll_cnt_q + 3'd1;
            clk_en_q   <= 1'b0;
            if (roll_cnt_q == num_q) begin
              valid_q <= 1'b1;
              state_q <= DONE;
            end else begin
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end
          end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_q <= 1'b1;
            clk_en_q  <= 1'b0;
            state_q   <= ABORT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= DRAIN;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ABORT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          clk_en_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ci_clk_en  = clk_en_q;
  assign ci_start   = start_q;
  assign ci_dataa   = {28'b0, die_q};
  assign ci_datab   = '0;
  assign o_busy     = busy_q;
  assign o_lastRoll = last_q;
  assign o_sum      = sum_q;
  assign o_valid    = valid_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_rng_ci_master.sv
// tb_rng_ci_master
//   Directed and randomized bench for rng_ci_master. A behavioural responder
//   answers each start after a programmable delay, holding done for a
//   programmable number of cycles, and returns results from a queue. Burst
//   expectations are the plain sum and last entry of that queue.
module tb_rng_ci_master;

  localparam int unsigned TO  = 16;
  localparam int unsigned GAP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_roll = 1'b0;
  logic [3:0]  i_dieSelect = '0;
  logic [2:0]  i_numRolls = '0;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_datab;
  logic [31:0] ci_result = '0;
  logic        ci_done;
  logic        o_busy;
  logic [4:0]  o_lastRoll;
  logic [7:0]  o_sum;
  logic        o_valid;
  logic        o_timeout;

  logic resp_done = 1'b0;
  logic stale_hi  = 1'b0;
  assign ci_done = resp_done | stale_hi;

  rng_ci_master #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .i_roll(i_roll), .i_dieSelect(i_dieSelect),
    .i_numRolls(i_numRolls), .ci_clk_en(ci_clk_en), .ci_start(ci_start),
    .ci_dataa(ci_dataa), .ci_datab(ci_datab), .ci_result(ci_result),
    .ci_done(ci_done), .o_busy(o_busy), .o_lastRoll(o_lastRoll),
    .o_sum(o_sum), .o_valid(o_valid), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Responder model
  int          resp_delay = 1;   // 0 = never answer
  int          resp_hold  = 1;
  logic [4:0]  rq[$];
  int          pend = 0;
  int          hcnt = 0;
  logic [31:0] rtmp;

  always @(negedge clk) begin
    if (reset) begin
      pend = 0; hcnt = 0; resp_done = 1'b0;
    end else begin
      if (resp_done) begin
        hcnt--;
        if (hcnt == 0) begin
          resp_done = 1'b0;
          ci_result = $urandom;
        end
      end
      if (ci_start && resp_delay > 0) begin
        pend = resp_delay;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rtmp = $urandom;
          rtmp[4:0] = (rq.size() > 0) ? rq.pop_front() : 5'd0;
          ci_result = rtmp;
          resp_done = 1'b1;
          hcnt = resp_hold;
        end
      end
    end
  end

  // Monitor
  int         cyc = 0;
  int         start_cnt = 0;
  int         valid_cnt = 0;
  int         to_cnt = 0;
  int         last_start_cyc = 0;
  int         last_to_cyc = 0;
  logic [3:0] exp_die = '0;
  logic       prev_start = 1'b0;

  always @(posedge clk) begin
    #3;
    cyc++;
    if (!reset) begin
      if (ci_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        check("start_after_done_low", ci_done, 0);
        check("start_one_cycle", prev_start, 0);
      end
      if (ci_clk_en) begin
        check("dataa_die", ci_dataa, {28'b0, exp_die});
        check("datab_zero", ci_datab, 0);
      end
      if (o_valid) valid_cnt++;
      if (o_timeout) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
    end
    prev_start = ci_start;
  end

  logic [4:0] model_last = '0;

  task automatic do_burst(input string tag, input logic [3:0] die, input logic [2:0] num,
                          input int stale_cyc, input bit noise, input int exp_lat);
    int sc, vc, tc, n, exp_sum;
    logic [4:0] exp_last;
    exp_sum = 0;
    foreach (rq[k]) exp_sum += int'(rq[k]);
    exp_last = rq[$];
    sc = start_cnt; vc = valid_cnt; tc = to_cnt;
    exp_die = die;
    @(posedge clk); #1;
    i_dieSelect = die; i_numRolls = num; i_roll = 1'b1;
    if (stale_cyc > 0) stale_hi = 1'b1;
    @(posedge clk); #1;
    i_roll = 1'b0;
    if (noise) i_numRolls = ~num;
    n = 0;
    if (stale_cyc > 0) begin
      repeat (stale_cyc) begin @(posedge clk); #1; end
      check({tag, "_no_start_while_done"}, start_cnt - sc, 0);
      check({tag, "_busy_in_drain"}, o_busy, 1);
      stale_hi = 1'b0;
      n = stale_cyc;
    end
    while (!(o_valid || o_timeout) && n < 3000) begin
      if (noise) begin
        i_roll = (n < 6) ? n[0] : 1'b0;
        i_dieSelect = ~die;
      end
      @(posedge clk); #1;
      n++;
    end
    i_roll = 1'b0;
    i_dieSelect = die;
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_no_timeout"}, o_timeout, 0);
    check({tag, "_sum"}, o_sum, exp_sum);
    check({tag, "_last"}, o_lastRoll, exp_last);
    check({tag, "_starts"}, start_cnt - sc, int'(num) + 1);
    if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, o_valid, 0);
    check({tag, "_idle"}, o_busy, 0);
    check({tag, "_valid_count"}, valid_cnt - vc, 1);
    check({tag, "_timeout_count"}, to_cnt - tc, 0);
    model_last = exp_last;
    rq.delete();
  endtask

  initial begin
    int sc, vc, tc, n;
    logic [2:0] num;
    logic [3:0] die;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_sum", o_sum, 0);
    check("rst_last", o_lastRoll, 0);
    check("rst_start", ci_start, 0);
    check("rst_clk_en", ci_clk_en, 0);
    check("rst_dataa", ci_dataa, 0);
    check("rst_datab", ci_datab, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single roll, done 5 cycles after start
    resp_delay = 5; resp_hold = 1;
    rq.push_back(5'd17);
    do_burst("one_roll", 4'd3, 3'd0, 0, 1'b0, 7);

    // Fastest single roll: o_valid four cycles after i_roll
    resp_delay = 1;
    rq.push_back(5'($urandom_range(0, 31)));
    do_burst("min_latency", 4'd12, 3'd0, 0, 1'b0, 3);

    // Four rolls with done held past the gap so drain has to wait
    resp_delay = 2; resp_hold = 6;
    rq.push_back(5'd4); rq.push_back(5'd6); rq.push_back(5'd1); rq.push_back(5'd20);
    do_burst("four_rolls", 4'd7, 3'd3, 0, 1'b0, -1);

    // Done stuck high before the request
    resp_delay = 3; resp_hold = 1;
    rq.push_back(5'($urandom_range(0, 31)));
    rq.push_back(5'($urandom_range(0, 31)));
    do_burst("stale_done", 4'd10, 3'd1, 8, 1'b0, -1);

    // Responder never answers
    resp_delay = 0;
    sc = start_cnt; vc = valid_cnt; tc = to_cnt;
    exp_die = 4'd5;
    @(posedge clk); #1;
    i_dieSelect = 4'd5; i_numRolls = 3'd0; i_roll = 1'b1;
    @(posedge clk); #1;
    i_roll = 1'b0;
    n = 0;
    while (!(o_valid || o_timeout) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_pulse", o_timeout, 1);
    check("to_no_valid", o_valid, 0);
    check("to_sum", o_sum, 0);
    check("to_last_kept", o_lastRoll, model_last);
    @(posedge clk); #1;
    check("to_pulse_len", o_timeout, 0);
    check("to_idle", o_busy, 0);
    check("to_distance", last_to_cyc - last_start_cyc, TO + 1);
    check("to_count", to_cnt - tc, 1);
    check("to_valid_count", valid_cnt - vc, 0);
    check("to_starts", start_cnt - sc, 1);

    // Done arrives on the final wait cycle: done wins over timeout
    resp_delay = TO; resp_hold = 1;
    rq.push_back(5'($urandom_range(0, 31)));
    do_burst("done_at_limit", 4'd1, 3'd0, 0, 1'b0, TO + 2);

    // Requests and die changes while busy are ignored
    resp_delay = 3; resp_hold = 2;
    repeat (3) rq.push_back(5'($urandom_range(0, 31)));
    do_burst("busy_ignore", 4'd6, 3'd2, 0, 1'b1, -1);
    repeat (4) begin @(posedge clk); #1; end
    check("busy_ignore_no_rerun", o_busy, 0);

    // Reset during the wait of roll 2 of 4
    resp_delay = 8; resp_hold = 1;
    repeat (4) rq.push_back(5'($urandom_range(0, 31)));
    sc = start_cnt; vc = valid_cnt; tc = to_cnt;
    exp_die = 4'd9;
    @(posedge clk); #1;
    i_dieSelect = 4'd9; i_numRolls = 3'd3; i_roll = 1'b1;
    @(posedge clk); #1;
    i_roll = 1'b0;
    n = 0;
    while (start_cnt - sc < 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("mid_rst_in_wait", ci_clk_en & ~ci_start, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_sum", o_sum, 0);
    check("mid_rst_last", o_lastRoll, 0);
    check("mid_rst_clk_en", ci_clk_en, 0);
    check("mid_rst_start", ci_start, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_timeout", o_timeout, 0);
    check("mid_rst_dataa", ci_dataa, 0);
    reset = 1'b0;
    rq.delete();
    model_last = '0;
    repeat (12) begin @(posedge clk); #1; end
    check("mid_rst_no_valid", valid_cnt - vc, 0);
    check("mid_rst_no_timeout", to_cnt - tc, 0);
    resp_delay = 2;
    repeat (3) rq.push_back(5'($urandom_range(0, 31)));
    do_burst("after_rst", 4'd2, 3'd2, 0, 1'b0, -1);

    // Largest sum: eight rolls of 31
    resp_delay = 1; resp_hold = 1;
    repeat (8) rq.push_back(5'd31);
    do_burst("max_sum", 4'd15, 3'd7, 0, 1'b0, -1);

    // Random bursts
    for (int b = 0; b < 6; b++) begin
      num = 3'($urandom_range(0, 7));
      die = 4'($urandom_range(0, 15));
      resp_delay = $urandom_range(1, 6);
      resp_hold  = $urandom_range(1, 7);
      for (int r = 0; r <= int'(num); r++) rq.push_back(5'($urandom_range(0, 31)));
      do_burst("rand", die, num, 0, b[0], -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
